// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared timing constants and types for the VGA block scanner.
//   - H_*_DEF / V_*_DEF : default 640x480@60 timing (25 MHz pixel clock)
//   - H_TOTAL / V_TOTAL : line and frame lengths for the default timing
//   - coord_t           : 10-bit pixel/line coordinate
//   - vga_phase_e       : phase of one scan axis (ACTIVE, FRONT, SYNC, BACK)
//   - BLOCK_W           : default sprite block edge length in pixels
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int BLOCK_W = 32;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } vga_phase_e;

endpackage

// File: rtl/vga_axis_fsm.sv
// ---------------------------------------------------------------------------
// vga_axis_fsm
// One scan axis: a wrapping counter plus the ACTIVE/FRONT/SYNC/BACK phase FSM.
// The phase always describes the current count value, so it can be used
// combinationally alongside the count.
//   clk    in   pixel clock
//   rst_n  in   asynchronous active-low reset (count=0, phase=ACTIVE)
//   inc    in   advance the axis by one step this cycle
//   count  out  current position on the axis
//   phase  out  phase of the current position
//   wrap   out  high when inc is set and count is at its last value
// ---------------------------------------------------------------------------
module vga_axis_fsm
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = H_ACTIVE_DEF,
  parameter int FP_LEN     = H_FP_DEF,
  parameter int SYNC_LEN   = H_SYNC_DEF,
  parameter int BP_LEN     = H_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output coord_t     count,
  output vga_phase_e phase,
  output logic       wrap
);

  // Last count value of each phase; the FSM leaves the phase after it.
  localparam coord_t LAST_ACTIVE = coord_t'(ACTIVE_LEN - 1);
  localparam coord_t LAST_FP     = coord_t'(ACTIVE_LEN + FP_LEN - 1);
  localparam coord_t LAST_SYNC   = coord_t'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam coord_t LAST_ALL    = coord_t'(ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN - 1);

  coord_t     count_reg, count_next;
  vga_phase_e phase_reg, phase_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      phase_reg <= ACTIVE;
    end else begin
      count_reg <= count_next;
      phase_reg <= phase_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    phase_next = phase_reg;
    wrap       = 1'b0;
    if (inc) begin
      if (count_reg == LAST_ALL) begin
        count_next = '0;
        wrap       = 1'b1;
      end else begin
        count_next = count_reg + 10'd1;
      end
      case (phase_reg)
        ACTIVE:  if (count_reg == LAST_ACTIVE) phase_next = FRONT;
        FRONT:   if (count_reg == LAST_FP)     phase_next = SYNC;
        SYNC:    if (count_reg == LAST_SYNC)   phase_next = BACK;
        BACK:    if (count_reg == LAST_ALL)    phase_next = ACTIVE;
        default: phase_next = ACTIVE;
      endcase
    end
  end

  assign count = count_reg;
  assign phase = phase_reg;

endmodule

// File: rtl/vga_block_scanner.sv
// ---------------------------------------------------------------------------
// vga_block_scanner
// VGA timing generator with a per-frame block hit test for sprite renderers.
// All outputs are registered and describe the counter state of the previous
// cycle (latency 1). The block position is latched on the last pixel of each
// frame so a block never tears.
//   clk          in   pixel clock (25 MHz for 640x480@60)
//   rst_n        in   asynchronous active-low reset
//   pos_x/pos_y  in   block top-left corner from game logic
//   hsync/vsync  out  active-low sync pulses
//   blank_n      out  high inside the visible area
//   x/y          out  current column / line
//   diff_x/y     out  offset inside the block, 0 when enable=0
//   enable       out  current visible pixel lies inside the block
//   frame_start  out  one-cycle pulse with x=0,y=0
// Build option: define BLOCK_TILE_H_EN to repeat the block across the full
// visible width within its rows (lat_x ignored, diff_x = low column bits).
// ---------------------------------------------------------------------------
module vga_block_scanner
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int BLOCK_SIZE = BLOCK_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] diff_x,
  output logic [9:0] diff_y,
  output logic       enable,
  output logic       frame_start
);

  coord_t     h_cnt, v_cnt;
  vga_phase_e h_phase, v_phase;
  logic       h_wrap, v_wrap;

  vga_axis_fsm #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .count (h_cnt),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_fsm #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (h_wrap),
    .count (v_cnt),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // Latched block position; v_wrap is exactly the last pixel of the frame.
  coord_t lat_x_reg, lat_y_reg;

  // Hit test in 11 bits so pos + BLOCK_SIZE cannot wrap around.
  logic       blank_n_next;
  logic       inx, iny, hit;
  coord_t     dx_raw, dy_raw;
  logic [10:0] y_end;

  assign blank_n_next = (h_phase == ACTIVE) && (v_phase == ACTIVE);
  assign y_end        = {1'b0, lat_y_reg} + 11'(BLOCK_SIZE);
  assign iny          = ({1'b0, v_cnt} >= {1'b0, lat_y_reg}) && ({1'b0, v_cnt} < y_end);
  assign dy_raw       = v_cnt - lat_y_reg;

`ifdef BLOCK_TILE_H_EN
  localparam int OFF_BITS = $clog2(BLOCK_SIZE);
  assign inx    = 1'b1;
  assign dx_raw = coord_t'(h_cnt[OFF_BITS-1:0]);
`else
  logic [10:0] x_end;
  assign x_end  = {1'b0, lat_x_reg} + 11'(BLOCK_SIZE);
  assign inx    = ({1'b0, h_cnt} >= {1'b0, lat_x_reg}) && ({1'b0, h_cnt} < x_end);
  assign dx_raw = h_cnt - lat_x_reg;
`endif

  // Visibility gating also clips blocks that extend past the right/bottom edge.
  assign hit = blank_n_next && inx && iny;

  logic   hsync_reg, vsync_reg, blank_n_reg, enable_reg, frame_start_reg;
  coord_t x_reg, y_reg, diff_x_reg, diff_y_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg           <= '0;
      y_reg           <= '0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      blank_n_reg     <= 1'b0;
      enable_reg      <= 1'b0;
      diff_x_reg      <= '0;
      diff_y_reg      <= '0;
      frame_start_reg <= 1'b0;
      lat_x_reg       <= '0;
      lat_y_reg       <= '0;
    end else begin
      x_reg           <= h_cnt;
      y_reg           <= v_cnt;
      hsync_reg       <= (h_phase != SYNC);
      vsync_reg       <= (v_phase != SYNC);
      blank_n_reg     <= blank_n_next;
      enable_reg      <= hit;
      diff_x_reg      <= hit ? dx_raw : '0;
      diff_y_reg      <= hit ? dy_raw : '0;
      frame_start_reg <= (h_cnt == '0) && (v_cnt == '0);
      if (v_wrap) begin
        lat_x_reg <= pos_x;
        lat_y_reg <= pos_y;
      end
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign blank_n     = blank_n_reg;
  assign enable      = enable_reg;
  assign diff_x      = diff_x_reg;
  assign diff_y      = diff_y_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_block_scanner.sv
// ---------------------------------------------------------------------------
// tb_vga_block_scanner
// Self-checking bench for vga_block_scanner. The timing is scaled down
// (136+4+8+4 = 152 columns, 92+2+2+4 = 100 lines, 15200 cycles per frame)
// so several whole frames fit in a short run; block size stays 32 and the
// block positions keep the same relations as the full 640x480 cases
// (full block, mid-frame move, block clipped 20x10 at the bottom-right).
// Honours BLOCK_TILE_H_EN for the horizontally tiled variant.
// ---------------------------------------------------------------------------
module tb_vga_block_scanner;

  localparam int HA = 136, HF = 4, HS = 8, HB = 4;
  localparam int VA = 92,  VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;   // 152
  localparam int VT = VA + VF + VS + VB;   // 100
  localparam int BS = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pos_x, pos_y;
  logic       hsync, vsync, blank_n, enable, frame_start;
  logic [9:0] x, y, diff_x, diff_y;

  vga_block_scanner #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .BLOCK_SIZE (BS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .x           (x),
    .y           (y),
    .diff_x      (diff_x),
    .diff_y      (diff_y),
    .enable      (enable),
    .frame_start (frame_start)
  );

  always #20 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (x=%0d y=%0d)", name, act, exp, x, y);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " x"}, int'(x), 0);
    check({tag, " y"}, int'(y), 0);
    check({tag, " hsync"}, int'(hsync), 1);
    check({tag, " vsync"}, int'(vsync), 1);
    check({tag, " blank_n"}, int'(blank_n), 0);
    check({tag, " enable"}, int'(enable), 0);
    check({tag, " diff_x"}, int'(diff_x), 0);
    check({tag, " diff_y"}, int'(diff_y), 0);
    check({tag, " frame_start"}, int'(frame_start), 0);
  endtask

  // One record per frame: latched position in force, position driven at
  // line 60 of this frame (for the next one), expected hit statistics.
  typedef struct {
    int lat_x, lat_y;
    int next_px, next_py;
    int en_cnt;
    int fx, fy, fdx, fdy;
    int lx, ly, ldx, ldy;
    int d70;
  } frame_vec_t;

  frame_vec_t vecs [4];

  initial begin
    int cycles, en_cnt, en_blank, diff_err, hs_cnt, vs_cnt, bl_cnt, hs_x, d70;
    int fx, fy, fdx, fdy, lx, ly, ldx, ldy, exp_dx, exp_dy;
    bit got_first, done;

`ifdef BLOCK_TILE_H_EN
    vecs[0] = '{0,   0,  100, 50,  4352, 0, 0,  0, 0,  135, 31, 7, 31, 0};
    vecs[1] = '{100, 50, 10,  50,  4352, 0, 50, 0, 0,  135, 81, 7, 31, 6};
    vecs[2] = '{10,  50, 116, 82,  4352, 0, 50, 0, 0,  135, 81, 7, 31, 6};
    vecs[3] = '{116, 82, 116, 82,  1360, 0, 82, 0, 0,  135, 91, 7, 9,  0};
`else
    vecs[0] = '{0,   0,  100, 50,  1024, 0,   0,  0, 0, 31,  31, 31, 31, 0};
    vecs[1] = '{100, 50, 10,  50,  1024, 100, 50, 0, 0, 131, 81, 31, 31, 0};
    vecs[2] = '{10,  50, 116, 82,  1024, 10,  50, 0, 0, 41,  81, 31, 31, 0};
    vecs[3] = '{116, 82, 116, 82,  200,  116, 82, 0, 0, 135, 91, 19, 9,  0};
`endif

    rst_n = 1'b0;
    pos_x = 10'd100;
    pos_y = 10'd50;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // First rising edge after release presents counter (0,0); lat is 0 there.
    rst_n = 1'b1;
    @(negedge clk);
    check("rel x", int'(x), 0);
    check("rel y", int'(y), 0);
    check("rel frame_start", int'(frame_start), 1);
    check("rel blank_n", int'(blank_n), 1);
    check("rel enable", int'(enable), 1);

    for (int f = 0; f < 4; f++) begin
      cycles = 0; en_cnt = 0; en_blank = 0; diff_err = 0;
      hs_cnt = 0; vs_cnt = 0; bl_cnt = 0; hs_x = -1; d70 = -1;
      fx = -1; fy = -1; fdx = -1; fdy = -1; lx = -1; ly = -1; ldx = -1; ldy = -1;
      got_first = 1'b0;
      done = 1'b0;
      while (!done) begin
        if (enable) begin
          en_cnt++;
          if (!got_first) begin
            got_first = 1'b1;
            fx = int'(x); fy = int'(y); fdx = int'(diff_x); fdy = int'(diff_y);
          end
          lx = int'(x); ly = int'(y); ldx = int'(diff_x); ldy = int'(diff_y);
          if (!blank_n) en_blank++;
`ifdef BLOCK_TILE_H_EN
          exp_dx = int'(x) % BS;
`else
          exp_dx = int'(x) - vecs[f].lat_x;
`endif
          exp_dy = int'(y) - vecs[f].lat_y;
          if (int'(diff_x) != exp_dx || int'(diff_y) != exp_dy) diff_err++;
        end else if (diff_x != 10'd0 || diff_y != 10'd0) begin
          diff_err++;
        end
        if (!hsync) begin
          hs_cnt++;
          if (hs_x < 0) hs_x = int'(x);
        end
        if (!vsync) vs_cnt++;
        if (blank_n) bl_cnt++;
        if (x == 10'd70 && y == 10'd60) d70 = int'(diff_x);
        if (x == 10'd0 && y == 10'd60) begin
          pos_x = 10'(vecs[f].next_px);
          pos_y = 10'(vecs[f].next_py);
        end
        @(negedge clk);
        cycles++;
        if (frame_start) begin
          done = 1'b1;
        end else if (cycles > 2 * HT * VT) begin
          check($sformatf("f%0d frame_start timeout", f), cycles, HT * VT);
          done = 1'b1;
        end
      end
      check($sformatf("f%0d frame period", f), cycles, HT * VT);
      check($sformatf("f%0d hsync low cycles", f), hs_cnt, HS * VT);
      check($sformatf("f%0d hsync first low x", f), hs_x, HA + HF);
      check($sformatf("f%0d vsync low cycles", f), vs_cnt, VS * HT);
      check($sformatf("f%0d blank_n high cycles", f), bl_cnt, HA * VA);
      check($sformatf("f%0d enable cycles", f), en_cnt, vecs[f].en_cnt);
      check($sformatf("f%0d enable while blank", f), en_blank, 0);
      check($sformatf("f%0d diff errors", f), diff_err, 0);
      check($sformatf("f%0d first hit x", f), fx, vecs[f].fx);
      check($sformatf("f%0d first hit y", f), fy, vecs[f].fy);
      check($sformatf("f%0d first diff_x", f), fdx, vecs[f].fdx);
      check($sformatf("f%0d first diff_y", f), fdy, vecs[f].fdy);
      check($sformatf("f%0d last hit x", f), lx, vecs[f].lx);
      check($sformatf("f%0d last hit y", f), ly, vecs[f].ly);
      check($sformatf("f%0d last diff_x", f), ldx, vecs[f].ldx);
      check($sformatf("f%0d last diff_y", f), ldy, vecs[f].ldy);
      check($sformatf("f%0d diff_x at (70,60)", f), d70, vecs[f].d70);
    end

    // Mid-frame asynchronous reset at x=100, y=60.
    cycles = 0;
    while (!(x == 10'd100 && y == 10'd60) && cycles < 2 * HT * VT) begin
      @(negedge clk);
      cycles++;
    end
    check("reach (100,60)", int'(x) * 1000 + int'(y), 100060);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs($sformatf("hold%0d", i));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post x", int'(x), 0);
    check("post y", int'(y), 0);
    check("post frame_start", int'(frame_start), 1);
    check("post blank_n", int'(blank_n), 1);
    check("post hsync", int'(hsync), 1);
    check("post enable", int'(enable), 1);
    @(negedge clk);
    check("post+1 x", int'(x), 1);
    check("post+1 frame_start", int'(frame_start), 0);
    check("post+1 diff_x", int'(diff_x), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_block_scanner.md
Name: vga_block_scanner

Overview:
- Pixel-timing initiator for the sprite/tile renderers. Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- For one block position it produces the scan coordinates x,y, the hit flag enable and the in-block offsets diff_x/diff_y. These are exactly the inputs a block renderer consumes to look up a 32x32 sprite pixel.
- Sits between the top-level clock divider and the renderers/colour mux. Block position is supplied by game logic and latched once per frame, so blocks never tear.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- BLOCK_SIZE, 32, block edge length in pixels (power of two)

Ports:
- clk  in  1  25 MHz pixel clock
- rst_n  in  1  asynchronous, active-low reset
- pos_x  in  10  block left column (game domain, sampled per frame)
- pos_y  in  10  block top row (sampled per frame)
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank_n  out  1  high inside the visible 640x480 area
- x  out  10  current column counter (0..799)
- y  out  10  current line counter (0..524)
- diff_x  out  10  column offset inside block, 0 when enable=0
- diff_y  out  10  row offset inside block, 0 when enable=0
- enable  out  1  current visible pixel lies inside the block
- frame_start  out  1  one-cycle pulse when x=0,y=0 is presented

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800; V_TOTAL=525.
- Internal counters h_cnt and v_cnt (10 bit).
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on an h_cnt wrap and wraps V_TOTAL-1 -> 0.
- Horizontal FSM tracks h_cnt with states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Transitions occur at h_cnt = 639/655/751/799 (parameter-derived). The vertical FSM is identical, driven by v_cnt at 479/489/491/524.
- All outputs are flops. The outputs at cycle n+1 are a function of the counters and latched positions at cycle n (latency 1).
- hsync=0 iff the H FSM is in SYNC (h_cnt 656..751). vsync=0 iff the V FSM is in SYNC (v_cnt 490..491).
- blank_n=1 iff both FSMs are in ACTIVE.
- Position latch:
  - lat_x/lat_y capture pos_x/pos_y on the cycle h_cnt=799 and v_cnt=524.
  - The new values apply from the next pixel (0,0) onward.
  - Changes to pos_* at any other time have no effect until the next frame.
- Hit test, using 11-bit arithmetic so pos+BLOCK_SIZE never overflows:
  - inx = h_cnt >= lat_x && h_cnt < lat_x+BLOCK_SIZE
  - iny likewise for v_cnt and lat_y
  - enable = blank_n_next && inx && iny
- diff_x = (h_cnt-lat_x)[9:0] and diff_y = (v_cnt-lat_y)[9:0] when enable, else 0. While enable=1, diff_x and diff_y are always < BLOCK_SIZE.
- Blocks partially off-screen (e.g. pos_x=620) are clipped. enable is 0 for columns >= 640.
- frame_start=1 for exactly the cycle when x=0 and y=0 is output.
- Reset values while rst_n=0: x=0, y=0, hsync=1, vsync=1, blank_n=0, enable=0, diff_x=0, diff_y=0, frame_start=0, counters=0, lat_x=0, lat_y=0.
- Reset assertion mid-frame forces these values immediately (asynchronously).
- After deassertion, the first rising edge presents counter (0,0): frame_start=1, blank_n=1.

Optional Feature:
- Macro: BLOCK_TILE_H_EN.
- Defined: within rows lat_y..lat_y+BLOCK_SIZE-1 the block repeats across the full visible width. inx is forced to 1, and diff_x = h_cnt[log2(BLOCK_SIZE)-1:0], zero-extended. lat_x is ignored. This renders ground/brick strips.
- Undefined: single block, as described in Behaviour.

Decomposition:
- Package vga_pkg holds:
  - the timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL)
  - typedef coord_t (logic [9:0])
  - typedef enum {ACTIVE, FRONT, SYNC, BACK} vga_phase_e
  - the constant BLOCK_W = 32
- One natural sub-module is vga_axis_fsm. It holds a counter plus the phase FSM, parameterised by active/fp/sync/bp. It is instantiated twice: horizontal with inc=1, vertical with inc=h_wrap. It outputs count, phase and wrap.

Test Plan:
- Reset release, free-run for 2 frames -> frame_start period is exactly 420000 cycles. hsync low for 96 cycles per 800-cycle line. vsync low for 1600 cycles per frame. blank_n high for 307200 cycles per frame.
- pos_x=100, pos_y=50 held -> enable high exactly 1024 cycles per frame.
  - First hit at x=100,y=50 with diff=(0,0).
  - Last hit at x=131,y=81 with diff=(31,31).
- pos_x=620, pos_y=470 -> clipped block. enable count = 20*10 = 200 per frame. No enable while blank_n=0.
- pos_x changed from 100 to 300 at y=60 mid-frame -> remaining rows of the current frame still hit at x=100..131. The next frame hits at x=300..331.
- rst_n asserted at x=400,y=200 for 3 cycles -> all outputs take reset values immediately. The first edge after release gives x=0,y=0, frame_start=1.
- With BLOCK_TILE_H_EN, pos_y=448 -> enable high for 640*32 = 20480 cycles per frame. diff_x at x=645 is not applicable (blank). diff_x at x=70 is 6.
